// File: rtl/axi_to_core.sv
// ============================================================================
// Module  : axi_to_core
// Brief   : AXI-stream slave that assembles one programming frame into the
//           core's programming register and holds off input while the core runs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module axi_to_core #(
  parameter int DATA_WIDTH_IN_STREAM = 32,
  parameter int PROGRAM_REG_SIZE     = 256
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic                            s_last,
  input  logic [DATA_WIDTH_IN_STREAM-1:0] s_data,
  input  logic                            core_done,
  output logic [PROGRAM_REG_SIZE-1:0]     program_data,
  output logic                            program_done,
  output logic                            len_err
);

  localparam int NUM_BEATS = PROGRAM_REG_SIZE / DATA_WIDTH_IN_STREAM;
  localparam int CNT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_BUSY  = 2'd3
  } state_t;

  state_t                      state;
  state_t                      state_nxt;
  logic [CNT_W-1:0]            beat_cnt;
  logic [CNT_W-1:0]            beat_cnt_nxt;
  logic [PROGRAM_REG_SIZE-1:0] shadow;
  logic [PROGRAM_REG_SIZE-1:0] shadow_nxt;
  logic [PROGRAM_REG_SIZE-1:0] program_data_nxt;
  logic                        ready_nxt;
  logic                        done_nxt;
  logic                        err_nxt;
  logic                        accept;

  assign accept = s_valid && s_ready;

  always_comb begin
    state_nxt        = state;
    beat_cnt_nxt     = beat_cnt;
    shadow_nxt       = shadow;
    program_data_nxt = program_data;
    done_nxt         = 1'b0;
    err_nxt          = 1'b0;

    case (state)
      ST_IDLE: begin
        state_nxt = ST_RECV;
      end

      ST_RECV: begin
        if (accept) begin
          for (int k = 0; k < NUM_BEATS; k++) begin
            if (beat_cnt == CNT_W'(k)) begin
              shadow_nxt[k*DATA_WIDTH_IN_STREAM +: DATA_WIDTH_IN_STREAM] = s_data;
            end
          end

          if (beat_cnt == LAST_BEAT) begin
            beat_cnt_nxt = '0;
            if (s_last) begin
              // Commit includes the beat arriving on this very edge.
              program_data_nxt = shadow_nxt;
              done_nxt         = 1'b1;
              state_nxt        = ST_BUSY;
            end else begin
              err_nxt   = 1'b1;
              state_nxt = ST_DRAIN;
            end
          end else if (s_last) begin
            err_nxt      = 1'b1;
            beat_cnt_nxt = '0;
          end else begin
            beat_cnt_nxt = beat_cnt + 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (accept && s_last) begin
          state_nxt = ST_RECV;
        end
      end

      ST_BUSY: begin
        if (core_done) begin
          state_nxt = ST_RECV;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    ready_nxt = (state_nxt == ST_RECV) || (state_nxt == ST_DRAIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      beat_cnt     <= '0;
      shadow       <= '0;
      program_data <= '0;
      s_ready      <= 1'b0;
      program_done <= 1'b0;
      len_err      <= 1'b0;
    end else begin
      state        <= state_nxt;
      beat_cnt     <= beat_cnt_nxt;
      shadow       <= shadow_nxt;
      program_data <= program_data_nxt;
      s_ready      <= ready_nxt;
      program_done <= done_nxt;
      len_err      <= err_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_to_core.sv
// ============================================================================
// Module  : tb_axi_to_core
// Brief   : Self-checking bench for axi_to_core: vector table, directed frame
//           sequences and randomized frames against a frame-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_axi_to_core;

  localparam int DW = 32;
  localparam int PW = 256;
  localparam int NB = PW / DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic          s_last = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          core_done = 1'b0;
  logic [PW-1:0] program_data;
  logic          program_done;
  logic          len_err;

  axi_to_core #(
    .DATA_WIDTH_IN_STREAM(DW),
    .PROGRAM_REG_SIZE    (PW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_last      (s_last),
    .s_data      (s_data),
    .core_done   (core_done),
    .program_data(program_data),
    .program_done(program_done),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Frame-level reference: a queue of pending beats plus busy/discard flags.
  logic          m_ready = 1'b0;
  logic          m_done = 1'b0;
  logic          m_err = 1'b0;
  logic [PW-1:0] m_pd = '0;
  logic [DW-1:0] m_q[$];
  bit            m_starting = 1'b0;
  bit            m_busy = 1'b0;
  bit            m_drain = 1'b0;
  bit            hs = 1'b0;

  int done_seen = 0;
  int err_seen = 0;
  int ready_seen = 0;

  typedef struct {
    bit            r;
    bit            v;
    bit            l;
    bit            cd;
    logic [DW-1:0] d;
    bit            er;
    bit            ed;
    bit            ee;
  } vec_t;

  vec_t tbl[14];

  task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit v, input bit l, input bit cd,
                            input logic [DW-1:0] d);
    hs = 1'b0;
    if (r) begin
      m_ready = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pd = '0;
      m_q.delete();
      m_starting = 1'b1; m_busy = 1'b0; m_drain = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_starting) begin
        m_starting = 1'b0;
        m_ready    = 1'b1;
      end else if (m_busy) begin
        if (cd) begin
          m_busy  = 1'b0;
          m_ready = 1'b1;
        end
      end else if (v && m_ready) begin
        hs = 1'b1;
        if (m_drain) begin
          if (l) m_drain = 1'b0;
        end else if (m_q.size() + 1 == NB) begin
          if (l) begin
            m_pd = '0;
            foreach (m_q[i]) m_pd[i*DW +: DW] = m_q[i];
            m_pd[(NB-1)*DW +: DW] = d;
            m_done  = 1'b1;
            m_busy  = 1'b1;
            m_ready = 1'b0;
          end else begin
            m_err   = 1'b1;
            m_drain = 1'b1;
          end
          m_q.delete();
        end else if (l) begin
          m_err = 1'b1;
          m_q.delete();
        end else begin
          m_q.push_back(d);
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit l, input bit cd,
                      input logic [DW-1:0] d);
    reset     = r;
    s_valid   = v;
    s_last    = l;
    core_done = cd;
    s_data    = d;
    @(posedge clk);
    model_edge(r, v, l, cd, d);
    #1;
    tests++;
    if (s_ready !== m_ready || program_done !== m_done || len_err !== m_err ||
        program_data !== m_pd) begin
      fails++;
      $display("FAIL model t=%0t: ready/done/err got %b%b%b expected %b%b%b, data got %h expected %h",
               $time, s_ready, program_done, len_err, m_ready, m_done, m_err, program_data, m_pd);
    end
    if (program_done === 1'b1) done_seen++;
    if (len_err === 1'b1) err_seen++;
    if (s_ready === 1'b1) ready_seen++;
  endtask

  task automatic send_beats(input int n, input logic [DW-1:0] base, input bit stall);
    for (int b = 0; b < n; b++) begin
      bit got = 1'b0;
      if (stall) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
      for (int t = 0; t < 40 && !got; t++) begin
        step(1'b0, 1'b1, (b == n - 1), 1'b0, base + DW'(b));
        if (hs) got = 1'b1;
      end
      if (!got) begin
        tests++;
        fails++;
        $display("FAIL handshake_timeout: beat %0d never accepted, expected acceptance", b);
      end
    end
  endtask

  function automatic logic [PW-1:0] pattern(input logic [DW-1:0] base);
    logic [PW-1:0] p;
    p = '0;
    for (int k = 0; k < NB; k++) p[k*DW +: DW] = base + DW'(k);
    return p;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    int bc;

    // Reset, good frame with beat k = k, busy hold, release, 1-beat short frame,
    // then core_done while receiving (ignored).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++)
      tbl[2+k] = '{1'b0, 1'b1, (k == 7), 1'b0, 32'(k), (k != 7), (k == 7), 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,    1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hdead, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0,    1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r, tbl[i].v, tbl[i].l, tbl[i].cd, tbl[i].d);
      check($sformatf("vec%0d_ready", i), {255'b0, s_ready}, {255'b0, tbl[i].er});
      check($sformatf("vec%0d_done", i), {255'b0, program_done}, {255'b0, tbl[i].ed});
      check($sformatf("vec%0d_err", i), {255'b0, len_err}, {255'b0, tbl[i].ee});
      if (i == 0) check("reset_data", program_data, '0);
    end
    check("frame_k_data", program_data, pattern(32'h0));

    // Source stalls: identical data, one done pulse.
    done_seen = 0;
    send_beats(8, 32'h0, 1'b1);
    check("stall_done_now", {255'b0, program_done}, {255'b0, 1'b1});
    check("stall_done_count", done_seen, 1);
    check("stall_data", program_data, pattern(32'h0));
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Short frame then good frame.
    done_seen = 0; err_seen = 0;
    send_beats(5, 32'h1000, 1'b0);
    check("short_err_count", err_seen, 1);
    check("short_no_done", done_seen, 0);
    check("short_data_kept", program_data, pattern(32'h0));
    send_beats(8, 32'hA5A5_0000, 1'b0);
    check("after_short_data", program_data, pattern(32'hA5A5_0000));
    check("after_short_done", done_seen, 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Long frame then good frame.
    done_seen = 0; err_seen = 0;
    send_beats(10, 32'h2000, 1'b0);
    check("long_err_count", err_seen, 1);
    check("long_no_done", done_seen, 0);
    check("long_data_kept", program_data, pattern(32'hA5A5_0000));
    send_beats(8, 32'h3000_0000, 1'b0);
    check("after_long_data", program_data, pattern(32'h3000_0000));

    // Busy hold-off with valid high, then release.
    ready_seen = 0;
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, $urandom);
    check("busy_ready_low", ready_seen, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("release_ready", {255'b0, s_ready}, {255'b0, 1'b1});
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("recv_cd_ignored", {255'b0, s_ready}, {255'b0, 1'b1});

    // Reset mid-frame, fresh frame, core_done in the first busy cycle.
    send_beats(3, 32'h4000, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    check("midrst_ready", {255'b0, s_ready}, '0);
    check("midrst_data", program_data, '0);
    check("midrst_flags", {254'b0, program_done, len_err}, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    check("midrst_ready_back", {255'b0, s_ready}, {255'b0, 1'b1});
    send_beats(8, 32'h5000, 1'b0);
    check("midrst_fresh_data", program_data, pattern(32'h5000));
    step(1'b0, 1'b0, 1'b0, 1'b1, '0);
    check("early_release_ready", {255'b0, s_ready}, {255'b0, 1'b1});

    // Randomized frames of varying length, stalls, core_done and rare resets.
    len = NB;
    bc  = 0;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      bit v;
      bit cd;
      bit l;
      r  = ($urandom_range(0, 399) == 0);
      v  = ($urandom_range(0, 3) != 0);
      cd = ($urandom_range(0, 5) == 0);
      l  = (bc == len - 1);
      step(r, v, l, cd, $urandom);
      if (r) begin
        bc = 0;
      end else if (hs) begin
        if (l) begin
          bc  = 0;
          len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, NB + 3)) : NB;
        end else begin
          bc++;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
